// File: rtl/main_mem_responder.sv
// ---------------------------------------------------------------------------
// main_mem_responder
//
// Line-granular main-memory model sitting on the memory side of the
// cache-to-memory interface. A request with data_main_vld high is a dirty-line
// writeback; any other request is a line fill. Each accepted request is
// answered with a one-cycle rsp_vld pulse exactly LATENCY cycles later.
// The requester holds its operands until it sees rsp_vld, so requests that
// arrive while busy are simply dropped.
//
// Optional feature (macro MAIN_MEM_RANGE_CHECK_EN):
//   defined   - requests with non-zero address bits above the line index are
//               answered with err=1. An erroneous write leaves the array
//               untouched, and an erroneous read returns zero.
//   undefined - those bits are ignored, so addresses alias modulo MEM_LINES,
//               and err is tied low.
//
// Ports:
//   clk            in   clock; all state changes on the rising edge
//   rst_n          in   asynchronous active-low reset
//   addr_main      in   request byte address (offset bits ignored)
//   addr_main_en   in   request strobe
//   data_main_in   in   writeback line data
//   data_main_vld  in   with addr_main_en, marks the request as a write
//   data_main_out  out  registered read line data, held between reads
//   rsp_vld        out  one-cycle response pulse
//   rsp_is_wr      out  qualifies rsp_vld: 1 = write ack, 0 = read data
//   mem_busy       out  request in flight; new requests are ignored
//   err            out  out-of-range flag alongside rsp_vld
// ---------------------------------------------------------------------------
module main_mem_responder #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int CACHE_WORD_WIDTH = 32,
    parameter int MEM_LINES        = 256,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       addr_main,
    input  logic                        addr_main_en,
    input  logic [CACHE_WORD_WIDTH-1:0] data_main_in,
    input  logic                        data_main_vld,
    output logic [CACHE_WORD_WIDTH-1:0] data_main_out,
    output logic                        rsp_vld,
    output logic                        rsp_is_wr,
    output logic                        mem_busy,
    output logic                        err
);

    localparam int OFFSET_WIDTH = $clog2(CACHE_WORD_WIDTH) - $clog2(DATA_WIDTH);
    localparam int LINE_IDX_W   = $clog2(MEM_LINES);
    localparam int HI_LSB       = OFFSET_WIDTH + LINE_IDX_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [CACHE_WORD_WIDTH-1:0] mem [MEM_LINES];

    logic [1:0]                  state_q;
    logic [3:0]                  cnt_q;
    logic [LINE_IDX_W-1:0]       idx_q;
    logic                        wr_q;
    logic                        err_q;
    logic [CACHE_WORD_WIDTH-1:0] wdata_q;

    logic [LINE_IDX_W-1:0]       req_idx;
    logic                        req_err;
    logic                        accept;
    logic                        load_rd;
    logic [CACHE_WORD_WIDTH-1:0] rd_data;
    logic                        unused_addr;

    assign req_idx = addr_main[OFFSET_WIDTH +: LINE_IDX_W];

`ifdef MAIN_MEM_RANGE_CHECK_EN
    assign req_err = |(addr_main >> HI_LSB);
`else
    assign req_err = 1'b0;
`endif

    // The offset bits (and, without range checking, the high bits) are
    // intentionally ignored.
    assign unused_addr = ^addr_main;

    // A new request can be taken in IDLE and in RESP, giving back-to-back
    // transactions with no idle gap.
    assign accept = addr_main_en && (state_q != S_WAIT);

    // Read data is captured on the edge that enters RESP. With LATENCY=1 this
    // is the acceptance edge itself, which can coincide with the commit of a
    // preceding write to the same line, so that write is forwarded.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        load_rd = 1'b0;
        rd_data = '0;
        if (state_q == S_WAIT) begin
            load_rd = (cnt_q == 4'd1) && !wr_q;
            if (!err_q) rd_data = mem[idx_q];
        end else if (accept && (LATENCY == 1)) begin
            load_rd = !data_main_vld;
            if (!req_err) begin
                if (state_q == S_RESP && wr_q && !err_q && idx_q == req_idx)
                    rd_data = wdata_q;
                else
                    rd_data = mem[req_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            wr_q          <= 1'b0;
            err_q         <= 1'b0;
            wdata_q       <= '0;
            data_main_out <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin  // IDLE, RESP
                    if (accept) begin
                        idx_q   <= req_idx;
                        wr_q    <= data_main_vld;
                        err_q   <= req_err;
                        if (data_main_vld) wdata_q <= data_main_in;
                        cnt_q   <= LAT_M1;
                        state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
            if (load_rd) data_main_out <= rd_data;
        end
    end

    // Writes commit at the edge ending RESP. A reset during the transaction
    // forces IDLE, so a discarded write never reaches the array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; its contents are undefined
        // until written, which lets it map onto block/distributed RAM.
        if (state_q == S_RESP && wr_q && !err_q) mem[idx_q] <= wdata_q;
    end

    assign rsp_vld   = (state_q == S_RESP);
    assign mem_busy  = (state_q == S_WAIT);
    assign rsp_is_wr = rsp_vld & wr_q;

`ifdef MAIN_MEM_RANGE_CHECK_EN
    assign err = rsp_vld & err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_main_mem_responder
//
// Self-checking bench for main_mem_responder (default parameters,
// LATENCY=4). The driver pushes the expected response of each request into a
// scoreboard queue. A monitor pops and compares each entry when rsp_vld
// appears. Honours MAIN_MEM_RANGE_CHECK_EN for the out-of-range cases.
// ---------------------------------------------------------------------------
module tb_main_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_main = '0;
    logic        addr_main_en = 1'b0;
    logic [31:0] data_main_in = '0;
    logic        data_main_vld = 1'b0;
    logic [31:0] data_main_out;
    logic        rsp_vld;
    logic        rsp_is_wr;
    logic        mem_busy;
    logic        err;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] model [256];
    logic [31:0] last_rd = '0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          rsp_count = 0;

    main_mem_responder #(.LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_main     (addr_main),
        .addr_main_en  (addr_main_en),
        .data_main_in  (data_main_in),
        .data_main_vld (data_main_vld),
        .data_main_out (data_main_out),
        .rsp_vld       (rsp_vld),
        .rsp_is_wr     (rsp_is_wr),
        .mem_busy      (mem_busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_err(input logic [15:0] a);
`ifdef MAIN_MEM_RANGE_CHECK_EN
        return a[15:10] != 6'd0;
`else
        return 1'b0;
`endif
    endfunction

    // Record the expected response and update the reference model.
    task automatic expect_req(input logic [15:0] a, input logic wr, input logic [31:0] d);
        logic [7:0] idx;
        logic       er;
        idx = a[9:2];
        er  = exp_err(a);
        if (wr) begin
            if (!er) model[idx] = d;
            sb.push_back('{wr: 1'b1, data: 32'h0, err: er});
        end else begin
            sb.push_back('{wr: 1'b0, data: (er ? 32'h0 : model[idx]), err: er});
        end
    endtask

    // Called at a negedge while the DUT is idle or in RESP: present the
    // request, hold it until rsp_vld, checking mem_busy and latency on the way.
    task automatic issue(input logic [15:0] a, input logic wr, input logic [31:0] d);
        int n;
        bit got;
        expect_req(a, wr, d);
        addr_main     = a;
        addr_main_en  = 1'b1;
        data_main_vld = wr;
        data_main_in  = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_vld) got = 1'b1;
            else check("busy_in_wait", mem_busy, 32'(LAT > 1));
        end
        check("latency", n, LAT);
    endtask

    task automatic idle(input int cycles);
        addr_main_en  = 1'b0;
        data_main_vld = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_vld) begin
                rsp_count++;
                if (sb.size() == 0) begin
                    check("spurious_rsp", rsp_vld, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_is_wr", rsp_is_wr, mon_e.wr);
                    check("err", err, mon_e.err);
                    if (mon_e.wr) begin
                        check("data_hold_on_wr", data_main_out, last_rd);
                    end else begin
                        check("rd_data", data_main_out, mon_e.data);
                        last_rd = mon_e.data;
                    end
                end
            end else begin
                check("err_outside_rsp", err, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_data_out", data_main_out, 0);
        check("rst_rsp_vld", rsp_vld, 0);
        check("rst_busy", mem_busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read with offset bits set.
        issue(16'h0040, 1'b1, 32'hDEADBEEF);
        idle(2);
        issue(16'h0042, 1'b0, 32'h0);
        idle(1);

        // Dirty eviction: read of the same line presented in the write's RESP.
        issue(16'h0100, 1'b1, 32'h11223344);
        issue(16'h0100, 1'b0, 32'h0);
        idle(1);

        // Request pulsed during WAIT is dropped.
        base = rsp_count;
        expect_req(16'h0500, 1'b1, 32'h5A5A5A5A);
        addr_main = 16'h0500; data_main_vld = 1'b1; data_main_in = 32'h5A5A5A5A;
        addr_main_en = 1'b1;
        @(negedge clk);
        addr_main_en = 1'b0;
        @(negedge clk);
        addr_main = 16'h0200; data_main_vld = 1'b0; addr_main_en = 1'b1;
        @(negedge clk);
        addr_main_en = 1'b0;
        repeat (8) @(negedge clk);
        check("drop_rsp_count", rsp_count - base, 1);

        // Reset in the middle of a write.
        issue(16'h0300, 1'b1, 32'h0);
        idle(1);
        issue(16'h0040, 1'b0, 32'h0);  // leaves non-zero read data on the output
        idle(1);
        base = rsp_count;
        addr_main = 16'h0300; data_main_vld = 1'b1; data_main_in = 32'hCAFEF00D;
        addr_main_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data_out", data_main_out, 0);
        check("midrst_rsp_vld", rsp_vld, 0);
        check("midrst_rsp_is_wr", rsp_is_wr, 0);
        check("midrst_busy", mem_busy, 0);
        check("midrst_err", err, 0);
        idle(3);
        rst_n = 1'b1;
        last_rd = '0;
        idle(6);
        check("midrst_no_rsp", rsp_count - base, 0);
        issue(16'h0300, 1'b0, 32'h0);
        idle(1);

        // High address bits: aliasing or error, depending on the build.
        issue(16'h4040, 1'b1, 32'hFFFFFFFF);
        idle(1);
        issue(16'h0040, 1'b0, 32'h0);
        idle(1);

        // Random back-to-back traffic over a few initialised lines.
        for (int i = 0; i < 8; i++) issue(16'((8'h20 + i) << 2), 1'b1, $urandom);
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a;
            a = 16'(((8'h20 + $urandom_range(0, 7)) << 2) | $urandom_range(0, 3));
            issue(a, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 4);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
